// File: rtl/dm_responder_pkg.sv
// -----------------------------------------------------------------------------
// dm_responder_pkg
//   Shared definitions for the data-memory responder:
//     - load type codes (RISC-V funct3 encoding of loads)
//     - FSM state encoding of the responder
//     - misalignment helpers, used when DM_MISALIGN_TRAP_EN is defined
// -----------------------------------------------------------------------------
package dm_responder_pkg;

  // Load types, RISC-V funct3 encoding
  localparam logic [2:0] DM_LB  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LW  = 3'b010;
  localparam logic [2:0] DM_LBU = 3'b100;
  localparam logic [2:0] DM_LHU = 3'b101;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dm_state_e;

  // A load is misaligned when a halfword is not on an even byte or a word
  // is not on a word boundary. Byte loads and unknown codes never are.
  function automatic logic dm_load_misaligned(input logic [2:0] dmtype,
                                               input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (dmtype)
      DM_LH, DM_LHU: bad = offset[0];
      DM_LW:         bad = (offset != 2'b00);
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

  // A store is well formed only when its lane mask is a single byte, an
  // aligned halfword or the full word. An empty mask counts as malformed.
  function automatic logic dm_store_misaligned(input logic [3:0] wea);
    logic bad;
    case (wea)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: bad = 1'b0;
      default:                   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_load_align.sv
// -----------------------------------------------------------------------------
// dm_load_align
//   Combinational load data alignment: picks the byte / halfword / word out of
//   a 32-bit memory word according to the byte offset and load type, then
//   sign- or zero-extends it to 32 bits. Unknown load types return zero.
//
//   Ports:
//     word    in  [31:0]  word read from the array
//     offset  in  [1:0]   byte offset within the word (addr[1:0])
//     dmtype  in  [2:0]   load type (funct3)
//     data    out [31:0]  extended load result
// -----------------------------------------------------------------------------
module dm_load_align
  import dm_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  dmtype,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    // Halfword selection uses only offset[1]; offset[0] is ignored here on
    // purpose so odd halfword addresses fall back to the enclosing halfword.
    half_sel = offset[1] ? word[31:16] : word[15:0];

    data = '0;
    case (dmtype)
      DM_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      DM_LBU:  data = {24'd0, byte_sel};
      DM_LH:   data = {{16{half_sel[15]}}, half_sel};
      DM_LHU:  data = {16'd0, half_sel};
      DM_LW:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//   Responder side of the CPU data-memory bus. One load/store is accepted per
//   valid/ready handshake; after WAIT_STATES extra cycles the access is
//   performed in a one-cycle DONE state and a single-cycle rsp_valid pulse is
//   returned. Accesses are strictly serialized, so a load always observes any
//   earlier store.
//
//   Parameters:
//     ADDR_WIDTH   word-index bits, array depth 2**ADDR_WIDTH words of 32 bits
//     WAIT_STATES  extra cycles between acceptance and response (0..15)
//
//   Ports:
//     clk        in   clock, all state on the rising edge
//     reset      in   synchronous, active-high reset
//     req_valid  in   request present
//     req_ready  out  request can be accepted this cycle
//     req_we     in   1 = store, 0 = load
//     wea        in   [3:0]  store byte-lane enables
//     addr       in   [31:0] byte address (bits above the index are ignored)
//     wdata      in   [31:0] store data, already lane-positioned
//     dmtype     in   [2:0]  load type (funct3)
//     rsp_valid  out  one-cycle response pulse
//     rdata      out  [31:0] load result (held across stores)
//     err        out  misalignment flag, qualified by rsp_valid
//
//   Build option:
//     DM_MISALIGN_TRAP_EN  when defined, misaligned accesses are suppressed
//                          (no write / zero load data) and flagged on err.
//                          When undefined, err is tied low.
// -----------------------------------------------------------------------------
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  wea,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dmtype,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // FSM and response state
  dm_state_e   state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rdata_reg, rdata_next;

  // Latched request
  logic                  we_reg;
  logic [3:0]            wea_reg;
  logic [ADDR_WIDTH-1:0] idx_reg;
  logic [1:0]            off_reg;
  logic [31:0]           wdata_reg;
  logic [2:0]            dmtype_reg;

  logic                  accept;
  logic                  mem_we;
  logic [3:0]            lane_we;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [31:0]           mem_word;
  logic [31:0]           load_data;
  logic                  access_bad;

  // Address bits above the word index alias onto the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  assign req_ready = (state_reg == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Request capture. Only written on an accepted handshake, so anything the
  // initiator does while the responder is busy is ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg     <= req_we;
      wea_reg    <= wea;
      idx_reg    <= addr[ADDR_WIDTH+1:2];
      off_reg    <= addr[1:0];
      wdata_reg  <= wdata;
      dmtype_reg <= dmtype;
    end
  end

  // ---------------------------------------------------------------------------
  // Misalignment qualification
  // ---------------------------------------------------------------------------
`ifdef DM_MISALIGN_TRAP_EN
  assign access_bad = we_reg ? dm_store_misaligned(wea_reg)
                             : dm_load_misaligned(dmtype_reg, off_reg);
`else
  assign access_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Word array: one byte-wide array per lane, synchronous write and
  // registered read. The read is issued on the edge that enters DONE, so the
  // word is ready during DONE. While IDLE the incoming address is used (a
  // zero-wait request goes straight to DONE on its accept edge); otherwise the
  // latched index is used.
  // ---------------------------------------------------------------------------
  assign rd_idx  = (state_reg == ST_IDLE) ? addr[ADDR_WIDTH+1:2] : idx_reg;
  assign lane_we = {4{mem_we}} & wea_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_reg;

      always_ff @(posedge clk) begin
        if (lane_we[gi]) begin
          lane_mem[idx_reg] <= wdata_reg[8*gi +: 8];
        end
        lane_rd_reg <= lane_mem[rd_idx];
      end

      assign mem_word[8*gi +: 8] = lane_rd_reg;
    end
  endgenerate

  dm_load_align u_load_align (
    .word   (mem_word),
    .offset (off_reg),
    .dmtype (dmtype_reg),
    .data   (load_data)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rdata_reg     <= rdata_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and access control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    rsp_valid_next = 1'b0;
    rdata_next     = rdata_reg;
    mem_we         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = ST_DONE;
          end else begin
            wait_cnt_next = 4'(WAIT_STATES - 1);
            state_next    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          state_next = ST_DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end

      ST_DONE: begin
        state_next     = ST_IDLE;
        rsp_valid_next = 1'b1;
        if (we_reg) begin
          // A reset landing on the DONE edge must not leave a partial write.
          mem_we = !access_bad && !reset;
        end else begin
          rdata_next = access_bad ? 32'd0 : load_data;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rsp_valid = rsp_valid_reg;
  assign rdata     = rdata_reg;

  // ---------------------------------------------------------------------------
  // Error flag
  // ---------------------------------------------------------------------------
`ifdef DM_MISALIGN_TRAP_EN
  logic err_reg;

  // err is only raised together with a response; it drops with rsp_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= (state_reg == ST_DONE) && access_bad;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
//   Two responders side by side: instance 0 with no wait states and instance 1
//   with three. A reference model of each bus target (word store keyed by
//   word index, a pending-transaction record and the last load result) is
//   advanced once per cycle and compared against both DUTs; directed requests
//   additionally check hand-computed results and latencies.
// -----------------------------------------------------------------------------
module tb_dm_responder;
  import dm_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, req_valid, req_ready, req_we, rsp_valid, err;
  logic [1:0][3:0]  wea;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][2:0]  dmtype;

  int cycle    = 0;
  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  dm_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .wea(wea[0]), .addr(addr[0]), .wdata(wdata[0]),
    .dmtype(dmtype[0]), .rsp_valid(rsp_valid[0]), .rdata(rdata[0]), .err(err[0])
  );

  dm_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .wea(wea[1]), .addr(addr[1]), .wdata(wdata[1]),
    .dmtype(dmtype[1]), .rsp_valid(rsp_valid[1]), .rdata(rdata[1]), .err(err[1])
  );

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 0 : 3;
  endfunction

  // ---------------------------------------------------------------- model ---
  logic [31:0] mem_m [int];
  bit          pend     [2];
  int          pend_cyc [2];
  logic        p_we     [2];
  logic [3:0]  p_wea    [2];
  logic [31:0] p_addr   [2];
  logic [31:0] p_wdata  [2];
  logic [2:0]  p_dt     [2];
  logic [31:0] last_rd  [2];

  // Load result from the funct3 rules, using shifts and two's-complement wrap.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] dt);
    int unsigned b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (dt)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      3'b010:  return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_bad(input logic we, input logic [3:0] w, input logic [31:0] a,
                                   input logic [2:0] dt);
`ifdef DM_MISALIGN_TRAP_EN
    if (we) return !(w inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    if (dt == 3'b001 || dt == 3'b101) return a[0];
    if (dt == 3'b010) return a[1:0] != 2'b00;
    return 1'b0;
`else
    return (we & 1'b0) | (^w & 1'b0) | (^a & 1'b0) | (^dt & 1'b0);
`endif
  endfunction

  task automatic check_bit(input string name, input int inst, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %b, expected %b", name, inst, cycle, act, exp);
    end
  endtask

  task automatic check_word(input string name, input int inst, input logic [31:0] act,
                            input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", name, inst, cycle, act, exp);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model, then model update
  // with this cycle's inputs (which take effect at the coming edge).
  always @(negedge clk) begin
    logic        exp_ready, due, bad;
    logic [31:0] exp_rd, w;
    int          key;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        exp_ready = !rst[i] && !(pend[i] && cycle < pend_cyc[i]);
        check_bit("req_ready", i, req_ready[i], exp_ready);
        due = pend[i] && (cycle == pend_cyc[i]);
        check_bit("rsp_valid", i, rsp_valid[i], due);
        if (due) begin
          key = i * 1024 + int'(p_addr[i][11:2]);
          bad = model_bad(p_we[i], p_wea[i], p_addr[i], p_dt[i]);
          if (p_we[i]) begin
            if (!bad) begin
              w = mem_m.exists(key) ? mem_m[key] : 32'd0;
              for (int l = 0; l < 4; l++)
                if (p_wea[i][l]) w[8*l +: 8] = p_wdata[i][8*l +: 8];
              mem_m[key] = w;
            end
            exp_rd = last_rd[i];
          end else begin
            exp_rd = bad ? 32'd0 : model_load(mem_m[key], p_addr[i], p_dt[i]);
          end
          check_word("rdata", i, rdata[i], exp_rd);
          check_bit("err", i, err[i], bad);
          last_rd[i] = exp_rd;
          pend[i]    = 1'b0;
        end else begin
          check_word("rdata_hold", i, rdata[i], last_rd[i]);
        end
        if (rst[i]) begin
          pend[i]    = 1'b0;
          last_rd[i] = 32'd0;
        end else if (req_valid[i] && exp_ready) begin
          pend[i]     = 1'b1;
          pend_cyc[i] = cycle + ws_of(i) + 2;
          p_we[i]     = req_we[i];
          p_wea[i]    = wea[i];
          p_addr[i]   = addr[i];
          p_wdata[i]  = wdata[i];
          p_dt[i]     = dmtype[i];
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus ---
  logic [31:0] r_data;
  logic        r_err;
  int          r_lat, r_low, r_pulse;

  // Called just after a rising edge with the request already driven; returns
  // the cycle in which the handshake completed, or -1 on timeout.
  task automatic wait_accept(input int inst, output int acc);
    acc = -1;
    for (int t = 0; t < 50 && acc < 0; t++) begin
      @(negedge clk);
      if (req_ready[inst]) acc = cycle;
      @(posedge clk); #1;
    end
    if (acc < 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL handshake[%0d]: no req_ready within 50 cycles", inst);
    end
  endtask

  task automatic do_req(input int inst, input logic we, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] dt, input bit hold);
    int acc;
    req_we[inst] = we; wea[inst] = w; addr[inst] = a; wdata[inst] = wd; dmtype[inst] = dt;
    req_valid[inst] = 1'b1;
    wait_accept(inst, acc);
    if (!hold) req_valid[inst] = 1'b0;
    r_data = 32'd0; r_err = 1'b0; r_lat = -1; r_low = 0; r_pulse = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (!req_ready[inst]) r_low++;
      if (rsp_valid[inst]) begin
        r_pulse++;
        if (r_lat < 0) begin
          r_lat  = cycle - acc;
          r_data = rdata[inst];
          r_err  = err[inst];
        end
      end
      @(posedge clk); #1;
      if (hold && cycle >= acc + ws_of(inst) + 2) req_valid[inst] = 1'b0;
    end
    req_valid[inst] = 1'b0;
    $display("txn[%0d] we=%b wea=%b addr=%h wdata=%h dt=%b -> rdata=%h err=%b lat=%0d",
             inst, we, w, a, wd, dt, r_data, r_err, r_lat);
  endtask

  task automatic store(input int inst, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] wd);
    do_req(inst, 1'b1, w, a, wd, DM_LW, 1'b0);
    check_word("store_latency", inst, r_lat, ws_of(inst) + 2);
  endtask

  task automatic load(input int inst, input logic [31:0] a, input logic [2:0] dt,
                      input logic [31:0] exp, input string name);
    do_req(inst, 1'b0, 4'h0, a, 32'd0, dt, 1'b0);
    check_word(name, inst, r_data, exp);
  endtask

  initial begin
    int acc, pulses;
    rst = 2'b11; req_valid = '0; req_we = '0; wea = '0; addr = '0; wdata = '0; dmtype = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pend_cyc[i] = 0; last_rd[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 2'b00;
    @(posedge clk); #1;

    // ---- zero wait states ----
    store(0, 4'hF, 32'h10, 32'hDEADBEEF);
    load(0, 32'h10, DM_LW, 32'hDEADBEEF, "lw_deadbeef");
    check_word("lw_latency", 0, r_lat, 2);

    store(0, 4'hF, 32'h10, 32'h80000001);
    load(0, 32'h13, DM_LB,  32'hFFFFFF80, "lb_13");
    load(0, 32'h13, DM_LBU, 32'h00000080, "lbu_13");
    load(0, 32'h12, DM_LH,  32'hFFFF8000, "lh_12");
    load(0, 32'h10, DM_LHU, 32'h00000001, "lhu_10");
    load(0, 32'h10, 3'b011, 32'h00000000, "bad_type");
    load(0, 32'h1010, DM_LW, 32'h80000001, "alias_wrap");

    store(0, 4'hF, 32'h00, 32'h12345678);
`ifdef DM_MISALIGN_TRAP_EN
    load(0, 32'h02, DM_LW, 32'h00000000, "lw_misaligned");
    check_bit("lw_misaligned_err", 0, r_err, 1'b1);
`else
    load(0, 32'h02, DM_LW, 32'h12345678, "lw_misaligned");
    check_bit("lw_misaligned_err", 0, r_err, 1'b0);
`endif

    // ---- three wait states ----
    store(1, 4'hF, 32'h20, 32'h11223344);
    do_req(1, 1'b0, 4'h0, 32'h20, 32'd0, DM_LW, 1'b1);
    check_word("hold_rdata", 1, r_data, 32'h11223344);
    check_word("hold_latency", 1, r_lat, 5);
    check_word("hold_busy_cycles", 1, r_low, 4);
    check_word("hold_pulses", 1, r_pulse, 1);

    store(1, 4'b0100, 32'h20, 32'h00AA0000);
    load(1, 32'h20, DM_LW, 32'h11AA3344, "byte_store");

    store(1, 4'b0000, 32'h20, 32'hFFFFFFFF);
    load(1, 32'h20, DM_LW, 32'h11AA3344, "empty_mask");

    // Reset during the WAIT state of a store aborts it.
    req_we[1] = 1'b1; wea[1] = 4'hF; addr[1] = 32'h20; wdata[1] = 32'hCAFEF00D;
    dmtype[1] = DM_LW; req_valid[1] = 1'b1;
    wait_accept(1, acc);
    req_valid[1] = 1'b0;
    @(posedge clk); #1 rst[1] = 1'b1;
    @(posedge clk); #1 rst[1] = 1'b0;
    @(negedge clk);
    check_bit("ready_after_reset", 1, req_ready[1], 1'b1);
    pulses = 0;
    for (int t = 0; t < 8; t++) begin
      if (rsp_valid[1]) pulses++;
      @(negedge clk);
    end
    check_word("abort_pulses", 1, pulses, 0);
    $display("txn[1] store aborted by reset, accept cycle %0d, pulses %0d", acc, pulses);
    @(posedge clk); #1;
    load(1, 32'h20, DM_LW, 32'h11AA3344, "after_abort");

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Target (responder) side of the CPU data-memory bus; the pipelined CPU is the initiator.
- Accepts one load/store request per valid/ready handshake and applies byte-lane writes to an internal word array.
- For loads, returns sign- or zero-extended sub-word data after a programmable number of wait states.
- Replaces the zero-latency data memory wherever the CPU must tolerate stalls.

Parameters:
- ADDR_WIDTH, 10, word-index bits; array depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_STATES, 0, extra cycles between acceptance and response (0..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- wea  input  4  store byte-lane enables; bit i writes bits 8i+7:8i.
- addr  input  32  byte address.
- wdata  input  32  store data, already lane-positioned.
- dmtype  input  3  load type: RISC-V funct3 encoding.
- rsp_valid  output  1  one-cycle response pulse.
- rdata  output  32  load result.
- err  output  1  misalignment flag, qualified by rsp_valid.

Behaviour:
- States: IDLE, WAIT, DONE. req_ready = (state==IDLE) && !reset.
- Reset values: state IDLE, rsp_valid 0, rdata 0, err 0, wait counter 0. Array contents are not reset.
- Accept: req_valid && req_ready at an edge. Latch req_we, wea, addr, wdata, dmtype.
  - WAIT_STATES==0: go to DONE.
  - Otherwise: counter = WAIT_STATES-1, go to WAIT.
- WAIT: decrement the counter each cycle; at 0, go to DONE.
- DONE (exactly one cycle): perform the access and, at the same edge, set rsp_valid=1 and return to IDLE.
- Latency: rsp_valid is high in cycle accept+WAIT_STATES+2. req_ready is high in the same cycle as rsp_valid, so back-to-back issue gives one request per WAIT_STATES+2 cycles.
- rsp_valid clears the cycle after it is high unless a new DONE occurs.
- Word index = addr[ADDR_WIDTH+1:2]. Higher address bits are ignored (aliases wrap modulo depth).
- Stores:
  - Lanes with wea bit set are updated; wea=0 is a legal no-op that still responds.
  - rdata holds its previous value.
- Loads: read the indexed word, then select by addr[1:0]:
  - 000 LB: byte addr[1:0], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword addr[1], sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: full word, addr[1:0] ignored.
  - Any other code: rdata=0.
- Inputs while not in IDLE are ignored. The initiator holds the request until req_ready.
- Reset asserted in WAIT or DONE: the access is aborted, no array write occurs, and no rsp_valid is produced.
- Store then load to the same word: the load observes the stored data, because accesses are strictly serialized.

Optional Feature:
- Macro DM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses: LH/LHU with addr[0]=1; LW with addr[1:0]!=0; stores whose wea is not 0001/0010/0100/1000/0011/1100/1111.
  - Misaligned stores skip the array write. Misaligned loads return rdata=0.
  - Both respond normally with err=1 in the rsp_valid cycle.
- Undefined: err is tied to 0 and misaligned accesses proceed with the low-bit rules above.

Decomposition:
- Shared package: dmtype constants DM_LB, DM_LH, DM_LW, DM_LBU, DM_LHU, and FSM state encodings.
- Sub-module dm_load_align: combinational extract/extend from {word, addr[1:0], dmtype} to 32 bits.

Test Plan:
- WAIT_STATES=0: store wdata=0xDEADBEEF, wea=1111, addr=0x10, then LW at 0x10 → rsp_valid exactly 2 cycles after each accept, rdata=0xDEADBEEF.
- Loads from word 0x80000001:
  - LB addr 0x13 → 0xFFFFFF80.
  - LBU addr 0x13 → 0x00000080.
  - LH addr 0x12 → 0xFFFF8000.
  - LHU addr 0x10 → 0x00000001.
- WAIT_STATES=3:
  - Hold req_valid through a busy period → req_ready low for 4 cycles, single response at accept+5, no duplicate accept.
  - Byte store wea=0100, wdata=0x00AA0000 to a word holding 0x11223344 → a subsequent LW returns 0x11AA3344.
- Reset pulsed in the WAIT state of a store → no rsp_valid, a later LW shows the old contents, req_ready=1 the cycle after reset deasserts.
- With DM_MISALIGN_TRAP_EN: LW at addr 0x02 → rsp_valid with err=1, rdata=0. Without the macro: same request → err=0, full word returned.
